// File: rtl/accum_pkg.sv
// Shared widths and FSM encoding for the accumulate-and-decimate path.
package accum_pkg;

  localparam int SUM_W      = 21;
  localparam int DATA_W     = 13;
  localparam int LOG2_N_MAX = SUM_W - DATA_W;

  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_WAIT_SUM = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_t;

endpackage

// File: rtl/avg_fifo.sv
// Two-entry first-word-fall-through buffer; the head entry is always on pop_data.
module avg_fifo #(
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        count_q;

  assign pop_data = head_q;
  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q  <= push_data;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              count_q <= 2'd1;
            end
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/accum_decimator.sv
// Counts 2^LOG2_N samples of an upstream running sum, then captures, rounds,
// saturates and queues the window average while clearing the upstream sum.
module accum_decimator #(
  parameter int LOG2_N = 8,
  parameter int SUM_W  = accum_pkg::SUM_W,
  parameter int DATA_W = accum_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_ce,
  input  logic [SUM_W-1:0]  acc_sum,
  output logic              acc_clr,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              ovf,
  output logic              sample_lost,
  output logic [1:0]        state_dbg
);
  import accum_pkg::*;

  if (LOG2_N < 1 || LOG2_N > LOG2_N_MAX || LOG2_N > SUM_W - DATA_W) begin : g_bad_log2_n
    $error("accum_decimator: LOG2_N=%0d outside 1..%0d", LOG2_N, SUM_W - DATA_W);
  end

  // Handshake: avg_data is transferred on every cycle where avg_valid && avg_ready;
  // while avg_valid is high and avg_ready low, avg_data holds its value.

  localparam logic [SUM_W:0] RND = {{SUM_W{1'b0}}, 1'b1} << (LOG2_N - 1);
  localparam logic [SUM_W:0] SAT = {{(SUM_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  state_t            state_q;
  state_t            state_d;
  logic [LOG2_N-1:0] cnt_q;
  logic              last_sample;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SUM_W:0]    sum_rnd;
  logic [SUM_W:0]    sum_div;
  logic [DATA_W-1:0] result;

  assign last_sample = sample_ce && (cnt_q == {LOG2_N{1'b1}});
  assign state_dbg   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COUNT:    if (last_sample) state_d = ST_WAIT_SUM;
      ST_WAIT_SUM: state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_COUNT;
      default:     state_d = ST_COUNT;
    endcase
  end

  // Clearing upstream during reset keeps its sum aligned with a zeroed counter.
  always_comb begin
    acc_clr = rst;
    push    = 1'b0;
    if (state_q == ST_CAPTURE) begin
      acc_clr = 1'b1;
      push    = !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_COUNT && sample_ce) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Round half up at one extra bit so a near-full sum cannot wrap.
  always_comb begin
    sum_rnd = {1'b0, acc_sum} + RND;
    sum_div = sum_rnd >> LOG2_N;
    if (sum_div > SAT) begin
      result = {DATA_W{1'b1}};
    end else begin
      result = sum_div[DATA_W-1:0];
    end
  end

  assign avg_valid = !fifo_empty;
  assign pop       = avg_valid && avg_ready;

  avg_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(result),
    .pop      (pop),
    .pop_data (avg_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf         <= 1'b0;
      sample_lost <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) begin
        ovf <= 1'b1;
      end
      if (sample_ce && state_q != ST_COUNT) begin
        sample_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accum_decimator.sv
// Directed bench for accum_decimator with LOG2_N=2 and a behavioural upstream accumulator.
module tb_accum_decimator;

  localparam int SUM_W  = 21;
  localparam int DATA_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_ce = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [SUM_W-1:0]  acc_sum = '0;
  logic              acc_clr;
  logic [DATA_W-1:0] avg_data;
  logic              avg_valid;
  logic              avg_ready = 1'b1;
  logic              ovf;
  logic              sample_lost;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_decimator #(
    .LOG2_N(2),
    .SUM_W (SUM_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_ce  (sample_ce),
    .acc_sum    (acc_sum),
    .acc_clr    (acc_clr),
    .avg_data   (avg_data),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .ovf        (ovf),
    .sample_lost(sample_lost),
    .state_dbg  (state_dbg)
  );

  // Upstream accumulator model: clear has priority over adding a sample.
  always @(posedge clk) begin
    if (acc_clr) acc_sum <= '0;
    else if (sample_ce) acc_sum <= acc_sum + SUM_W'(sample_in);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives one sample for one cycle; returns one cycle after the sample cycle.
  task automatic send(input int v);
    sample_ce = 1'b1;
    sample_in = DATA_W'(v);
    tick();
    sample_ce = 1'b0;
  endtask

  // Four samples at 4-cycle spacing; returns 4 cycles after the last sample.
  task automatic window(input int a, input int b, input int c, input int d);
    send(a); idle(3);
    send(b); idle(3);
    send(c); idle(3);
    send(d); idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (acc_clr !== 1'b1) begin errors++; $display("FAIL reset_acc_clr got=%b exp=1", acc_clr); end
    rst = 1'b0;
    #1;
    checks++;
    if (avg_valid !== 1'b0 || avg_data !== '0 || ovf !== 1'b0 || sample_lost !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got valid=%b data=%0d ovf=%b lost=%b st=%0d exp 0/0/0/0/0",
               avg_valid, avg_data, ovf, sample_lost, state_dbg);
    end
    checks++;
    if (acc_clr !== 1'b0) begin errors++; $display("FAIL reset_release_clr got=%b exp=0", acc_clr); end
  endtask

  task automatic test_basic();
    avg_ready = 1'b1;
    send(10); idle(3);
    send(20); idle(3);
    send(30); idle(3);
    send(40);
    checks++;
    if (acc_clr !== 1'b0) begin errors++; $display("FAIL basic_clr_t1 got=%b exp=0", acc_clr); end
    tick();
    checks++;
    if (acc_clr !== 1'b1 || avg_valid !== 1'b0) begin
      errors++; $display("FAIL basic_clr_t2 got clr=%b valid=%b exp clr=1 valid=0", acc_clr, avg_valid);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd25 || acc_clr !== 1'b0) begin
      errors++; $display("FAIL basic_avg got valid=%b data=%0d clr=%b exp 1/25/0", avg_valid, avg_data, acc_clr);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got valid=%b exp=0", avg_valid); end
  endtask

  task automatic test_rounding();
    send(1); idle(3); send(1); idle(3); send(1); idle(3); send(2); idle(2);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd1) begin
      errors++; $display("FAIL round_down got valid=%b data=%0d exp 1/1", avg_valid, avg_data);
    end
    tick();
    send(1); idle(3); send(1); idle(3); send(2); idle(3); send(2); idle(2);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd2) begin
      errors++; $display("FAIL round_up got valid=%b data=%0d exp 1/2", avg_valid, avg_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    avg_ready = 1'b0;
    window(8, 8, 8, 8);
    window(8, 8, 8, 8);
    checks++;
    if (ovf !== 1'b0 || avg_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_two_held got ovf=%b valid=%b exp 0/1", ovf, avg_valid);
    end
    window(8, 8, 8, 8);
    checks++;
    if (ovf !== 1'b1 || avg_valid !== 1'b1 || avg_data !== 13'd8) begin
      errors++; $display("FAIL ovf_dropped got ovf=%b valid=%b data=%0d exp 1/1/8", ovf, avg_valid, avg_data);
    end
    avg_ready = 1'b1;
    tick();
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd8) begin
      errors++; $display("FAIL ovf_second got valid=%b data=%0d exp 1/8", avg_valid, avg_data);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drained got valid=%b ovf=%b exp 0/1", avg_valid, ovf);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    avg_ready = 1'b0;
    window(4, 4, 4, 4);
    window(12, 12, 12, 12);
    send(20); idle(3); send(20); idle(3); send(20); idle(3); send(20);
    tick();
    checks++;
    if (acc_clr !== 1'b1 || avg_data !== 13'd4) begin
      errors++; $display("FAIL fullpop_capture got clr=%b data=%0d exp 1/4", acc_clr, avg_data);
    end
    avg_ready = 1'b1;
    tick();
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd12 || ovf !== 1'b0) begin
      errors++; $display("FAIL fullpop_accept got valid=%b data=%0d ovf=%b exp 1/12/0", avg_valid, avg_data, ovf);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd20) begin
      errors++; $display("FAIL fullpop_third got valid=%b data=%0d exp 1/20", avg_valid, avg_data);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL fullpop_empty got valid=%b ovf=%b exp 0/0", avg_valid, ovf);
    end
  endtask

  task automatic test_sample_lost();
    do_reset();
    avg_ready = 1'b1;
    send(5); idle(3); send(5); idle(3); send(5); idle(3); send(5);
    checks++;
    if (state_dbg !== 2'd1 || sample_lost !== 1'b0) begin
      errors++; $display("FAIL lost_wait_state got st=%0d lost=%b exp 1/0", state_dbg, sample_lost);
    end
    // Extra sample lands in WAIT_SUM: upstream adds it, the counter must not.
    send(7);
    checks++;
    if (sample_lost !== 1'b1 || acc_clr !== 1'b1) begin
      errors++; $display("FAIL lost_flag got lost=%b clr=%b exp 1/1", sample_lost, acc_clr);
    end
    tick();
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd7) begin
      errors++; $display("FAIL lost_avg got valid=%b data=%0d exp 1/7", avg_valid, avg_data);
    end
    idle(3);
    send(40); idle(3); send(40); idle(3); send(40); idle(3);
    checks++;
    if (avg_valid !== 1'b0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL lost_three_not_window got valid=%b st=%0d exp 0/0", avg_valid, state_dbg);
    end
    send(40); idle(2);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd40 || sample_lost !== 1'b1) begin
      errors++; $display("FAIL lost_next_window got valid=%b data=%0d lost=%b exp 1/40/1", avg_valid, avg_data, sample_lost);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    avg_ready = 1'b1;
    send(50); idle(3); send(50); idle(3);
    rst = 1'b1;
    #1;
    checks++;
    if (acc_clr !== 1'b1) begin errors++; $display("FAIL midrst_clr got=%b exp=1", acc_clr); end
    tick();
    rst = 1'b0;
    idle(6);
    checks++;
    if (avg_valid !== 1'b0 || sample_lost !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_no_result got valid=%b lost=%b ovf=%b exp 0/0/0", avg_valid, sample_lost, ovf);
    end
    send(100); idle(3); send(100); idle(3); send(100); idle(3); send(100); idle(2);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 13'd100) begin
      errors++; $display("FAIL midrst_fresh got valid=%b data=%0d exp 1/100", avg_valid, avg_data);
    end
    tick();
    send(60); idle(3); send(60); idle(3); send(60); idle(3); send(60); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    checks++;
    if (avg_valid !== 1'b0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL capture_rst got valid=%b st=%0d exp 0/0", avg_valid, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_full_pop();
    test_sample_lost();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
